// File: rtl/fwd_hazard_ctrl_if.sv
// Forwarding/hazard control bundle between the
// ID-stage driver and the hazard controller.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  pipe_en;
  logic                  flush;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  stall;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output pipe_en, flush,
    output id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_reg_write,
    output id_mem_read,
    input  fwd_a_sel, fwd_b_sel,
    input  stall, stall_count
  );

  modport slave (
    input  pipe_en, flush,
    input  id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_reg_write,
    input  id_mem_read,
    output fwd_a_sel, fwd_b_sel,
    output stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generation and
// load-use stall detection with stall counter.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_ctrl_if.slave bus
);

  typedef logic [REG_ADDR_W-1:0] ridx_t;

  typedef struct packed {
    ridx_t rs1;
    ridx_t rs2;
    ridx_t rd;
    logic  rw;
    logic  mr;
  } id_ex_t;

  typedef struct packed {
    ridx_t rd;
    logic  rw;
  } wr_t;

  id_ex_t           ex_q;
  wr_t              mem_q;
  wr_t              wb_q;
  logic [CNT_W-1:0] cnt_q;

  logic             stall;
  logic             hit1;
  logic             hit2;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  id_ex_t           id_ex;

  // load in EX whose rd feeds the ID instruction
  always_comb begin
    hit1 = bus.id_use_rs1
         && (bus.id_rs1 == ex_q.rd);
    hit2 = bus.id_use_rs2
         && (bus.id_rs2 == ex_q.rd);
    stall = ex_q.mr
          && (ex_q.rd != '0)
          && (hit1 || hit2)
          && !bus.flush;
  end

  // operand A select, EX/MEM holds newest value
  always_comb begin
    sel_a = 2'b00;
    priority case (1'b1)
      mem_q.rw && mem_q.rd != '0
        && mem_q.rd == ex_q.rs1:
        sel_a = 2'b10;
      wb_q.rw && wb_q.rd != '0
        && wb_q.rd == ex_q.rs1:
        sel_a = 2'b01;
      default: sel_a = 2'b00;
    endcase
  end

  // operand B select, same priority as A
  always_comb begin
    sel_b = 2'b00;
    priority case (1'b1)
      mem_q.rw && mem_q.rd != '0
        && mem_q.rd == ex_q.rs2:
        sel_b = 2'b10;
      wb_q.rw && wb_q.rd != '0
        && wb_q.rd == ex_q.rs2:
        sel_b = 2'b01;
      default: sel_b = 2'b00;
    endcase
  end

  // next ID/EX content: ID fields or bubble
  always_comb begin
    id_ex = '0;
    if (!(stall || bus.flush)) begin
      id_ex.rs1 = bus.id_rs1;
      id_ex.rs2 = bus.id_rs2;
      id_ex.rd  = bus.id_rd;
      id_ex.rw  = bus.id_reg_write;
      id_ex.mr  = bus.id_mem_read;
    end
  end

  // shadow pipeline registers and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (bus.pipe_en) begin
      wb_q     <= mem_q;
      mem_q.rd <= ex_q.rd;
      mem_q.rw <= ex_q.rw;
      ex_q     <= id_ex;
      if (stall && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.fwd_a_sel   = sel_a;
  assign bus.fwd_b_sel   = sel_b;
  assign bus.stall       = stall;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed checks for fwd_hazard_ctrl:
// forwarding selects, load-use stall, freeze, reset.
module tb_fwd_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;

  fwd_hazard_ctrl_if #(
    .REG_ADDR_W(5),
    .CNT_W(32)
  ) bus ();

  fwd_hazard_ctrl #(
    .REG_ADDR_W(5),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       u1,
    input logic       u2,
    input logic [4:0] rd,
    input logic       rw,
    input logic       mr
  );
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    #1;
  endtask

  task automatic nop();
    id(5'd0, 5'd0, 1'b0, 1'b0,
       5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) cyc();
  endtask

  initial begin
    n_pass      = 0;
    n_tot       = 0;
    rst         = 1'b1;
    bus.pipe_en = 1'b1;
    bus.flush   = 1'b0;
    nop();
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("rst_a", 32'(bus.fwd_a_sel), 32'd0);
    chk("rst_b", 32'(bus.fwd_b_sel), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_cnt", bus.stall_count, 32'd0);

    // add x5,x1,x2 ; sub x6,x5,x1
    id(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    cyc();
    id(5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
    chk("b2b_stall", 32'(bus.stall), 32'd0);
    cyc();
    chk("b2b_a", 32'(bus.fwd_a_sel), 32'd2);
    chk("b2b_b", 32'(bus.fwd_b_sel), 32'd0);
    drain();

    // add x5 ; nop ; or x7,x1,x5
    id(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    cyc();
    nop();
    cyc();
    id(5'd1, 5'd5, 1, 1, 5'd7, 1, 0);
    cyc();
    chk("d2_a", 32'(bus.fwd_a_sel), 32'd0);
    chk("d2_b", 32'(bus.fwd_b_sel), 32'd1);
    drain();

    // add x5 ; add x5 ; sub x6,x5,x0
    id(5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    cyc();
    id(5'd3, 5'd4, 1, 1, 5'd5, 1, 0);
    cyc();
    id(5'd5, 5'd0, 1, 1, 5'd6, 1, 0);
    cyc();
    chk("dbl_a", 32'(bus.fwd_a_sel), 32'd2);
    chk("dbl_b", 32'(bus.fwd_b_sel), 32'd0);
    drain();

    // lw x5 ; add x6,x5,x5
    id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
    cyc();
    id(5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
    chk("lu_stall", 32'(bus.stall), 32'd1);
    cyc();
    chk("lu_stall2", 32'(bus.stall), 32'd0);
    chk("lu_cnt", bus.stall_count, 32'd1);
    cyc();
    chk("lu_a", 32'(bus.fwd_a_sel), 32'd1);
    chk("lu_b", 32'(bus.fwd_b_sel), 32'd1);
    drain();

    // lw x0 ; use x0
    id(5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
    cyc();
    id(5'd0, 5'd0, 1, 1, 5'd7, 1, 0);
    chk("x0_stall", 32'(bus.stall), 32'd0);
    cyc();
    chk("x0_a", 32'(bus.fwd_a_sel), 32'd0);
    chk("x0_b", 32'(bus.fwd_b_sel), 32'd0);
    chk("x0_cnt", bus.stall_count, 32'd1);
    drain();

    // lw x5 ; add x6,x5,x5 flushed
    id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
    cyc();
    id(5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
    bus.flush = 1'b1;
    #1;
    chk("fl_stall", 32'(bus.stall), 32'd0);
    cyc();
    bus.flush = 1'b0;
    nop();
    chk("fl_cnt", bus.stall_count, 32'd1);
    cyc();
    chk("fl_a", 32'(bus.fwd_a_sel), 32'd0);
    chk("fl_b", 32'(bus.fwd_b_sel), 32'd0);
    drain();

    // freeze during a load-use stall
    id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
    cyc();
    id(5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
    chk("fz_stall0", 32'(bus.stall), 32'd1);
    bus.pipe_en = 1'b0;
    repeat (3) cyc();
    chk("fz_stall", 32'(bus.stall), 32'd1);
    chk("fz_cnt", bus.stall_count, 32'd1);
    bus.pipe_en = 1'b1;
    #1;
    cyc();
    chk("fz_cnt2", bus.stall_count, 32'd2);
    chk("fz_stall2", 32'(bus.stall), 32'd0);
    cyc();
    chk("fz_a", 32'(bus.fwd_a_sel), 32'd1);
    chk("fz_b", 32'(bus.fwd_b_sel), 32'd0);
    drain();

    // reset asserted mid-stall
    id(5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
    cyc();
    id(5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
    chk("rm_stall0", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    cyc();
    chk("rm_stall", 32'(bus.stall), 32'd0);
    chk("rm_cnt", bus.stall_count, 32'd0);
    chk("rm_a", 32'(bus.fwd_a_sel), 32'd0);
    chk("rm_b", 32'(bus.fwd_b_sel), 32'd0);
    rst = 1'b0;
    #1;

    $display("%0d/%0d checks passed",
             n_pass, n_tot);
    $finish;
  end

endmodule
